// File: rtl/fetch_sequencer.sv
// Fetch-stage PC owner: issues req/ack reads to instruction memory and hands
// registered InstrF/PCF/PCPlus4F/InstrValidF to the IF/ID register.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        Redirect,
    input  logic [31:0] RedirectTarget,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic        InstrValidF
);

    typedef enum logic [1:0] {BOOT, FETCH, HOLD, KILL} state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic        pending_reg, pending_next;
    logic [31:0] kill_addr_reg, kill_addr_next;
    logic [31:0] skid_instr_reg, skid_instr_next;
    logic [31:0] skid_pc_reg, skid_pc_next;
    logic [31:0] instr_reg, instr_next;
    logic [31:0] pcf_reg, pcf_next;
    logic        valid_reg, valid_next;
    logic        req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= BOOT;
            pc_reg         <= RESET_PC;
            pending_reg    <= 1'b0;
            kill_addr_reg  <= RESET_PC;
            skid_instr_reg <= NOP_INSTR;
            skid_pc_reg    <= RESET_PC;
            instr_reg      <= NOP_INSTR;
            pcf_reg        <= RESET_PC;
            valid_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            pending_reg    <= pending_next;
            kill_addr_reg  <= kill_addr_next;
            skid_instr_reg <= skid_instr_next;
            skid_pc_reg    <= skid_pc_next;
            instr_reg      <= instr_next;
            pcf_reg        <= pcf_next;
            valid_reg      <= valid_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        pending_next    = pending_reg;
        kill_addr_next  = kill_addr_reg;
        skid_instr_next = skid_instr_reg;
        skid_pc_next    = skid_pc_reg;
        instr_next      = instr_reg;
        pcf_next        = pcf_reg;
        valid_next      = valid_reg;
        req             = 1'b0;

        case (state_reg)
            BOOT: state_next = FETCH;
            FETCH: begin
                // A raised request is held until acked even if a stall arrives.
                req          = pending_reg || !StallF;
                pending_next = req && !imem_ack;
                if (req && imem_ack) begin
                    pc_next = pc_reg + 32'd4;
                    if (!StallF) begin
                        instr_next = imem_rdata;
                        pcf_next   = pc_reg;
                        valid_next = 1'b1;
                    end else begin
                        skid_instr_next = imem_rdata;
                        skid_pc_next    = pc_reg;
                        state_next      = HOLD;
                    end
                end else if (!StallF) begin
                    instr_next = NOP_INSTR;
                    valid_next = 1'b0;
                end
            end
            HOLD: begin
                if (!StallF) begin
                    instr_next = skid_instr_reg;
                    pcf_next   = skid_pc_reg;
                    valid_next = 1'b1;
                    state_next = FETCH;
                end
            end
            KILL: begin
                req = 1'b1;
                if (imem_ack) state_next = FETCH;
            end
            default: state_next = BOOT;
        endcase

        // Redirect overrides everything; an unfinished read is drained in KILL
        // at its original address so the memory handshake stays legal.
        if (Redirect) begin
            pc_next      = RedirectTarget & ~32'h3;
            instr_next   = NOP_INSTR;
            valid_next   = 1'b0;
            pcf_next     = pcf_reg;
            pending_next = 1'b0;
            if (req && !imem_ack) begin
                state_next = KILL;
                if (state_reg != KILL) kill_addr_next = pc_reg;
            end else begin
                state_next = FETCH;
            end
        end
    end

    assign imem_req    = req;
    assign imem_addr   = ((state_reg == KILL) ? kill_addr_reg : pc_reg) & ~32'h3;
    assign InstrF      = instr_reg;
    assign PCF         = pcf_reg;
    assign PCPlus4F    = pcf_reg + 32'd4;
    assign InstrValidF = valid_reg;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: zero/two-wait memory, stall skid,
// redirect kill, redirect-vs-stall priority, PC wrap and async reset.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset, StallF, Redirect;
    logic [31:0] RedirectTarget;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] InstrF, PCF, PCPlus4F;
    logic        InstrValidF;

    logic        rst6;
    logic        req6, ack6, valid6, mode6;
    logic [31:0] addr6, instr6, pcf6, pcp46;

    logic        ack_mode, man_ack;
    logic [3:0]  ws, cnt;
    int          n_vec = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk(clk), .reset(reset), .StallF(StallF), .Redirect(Redirect),
        .RedirectTarget(RedirectTarget), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .InstrF(InstrF), .PCF(PCF),
        .PCPlus4F(PCPlus4F), .InstrValidF(InstrValidF)
    );

    fetch_sequencer #(.RESET_PC(32'hFFFF_FFF8)) dut6 (
        .clk(clk), .reset(rst6), .StallF(1'b0), .Redirect(1'b0),
        .RedirectTarget(32'h0), .imem_req(req6), .imem_addr(addr6),
        .imem_ack(ack6), .imem_rdata(addr6 | 32'h1), .InstrF(instr6), .PCF(pcf6),
        .PCPlus4F(pcp46), .InstrValidF(valid6)
    );

    // Memory model: word at address a reads as a|1; ack after ws wait cycles.
    assign imem_rdata = imem_addr | 32'h1;
    assign imem_ack   = ack_mode ? man_ack : (imem_req && (cnt == ws));
    assign ack6       = req6 && !mode6;

    always @(posedge clk) begin
        if (imem_req && !imem_ack) cnt <= cnt + 4'd1;
        else                       cnt <= 4'd0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; rst6 = 1'b1; mode6 = 1'b0;
        StallF = 1'b0; Redirect = 1'b0; RedirectTarget = 32'h0;
        ack_mode = 1'b0; man_ack = 1'b0; ws = 4'd0; cnt = 4'd0;
        #2;
        chk("rst_req",    {31'b0, imem_req}, 32'h0);
        chk("rst_instr",  InstrF, 32'h13);
        chk("rst_pcf",    PCF, 32'h0);
        chk("rst_pcp4",   PCPlus4F, 32'h4);
        chk("rst_valid",  {31'b0, InstrValidF}, 32'h0);
        tick(); tick();
        reset = 1'b0;
        #1 chk("boot_req", {31'b0, imem_req}, 32'h0);

        // T1: zero-wait memory
        tick(); #1;
        chk("t1_req0",   {31'b0, imem_req}, 32'h1);
        chk("t1_addr0",  imem_addr, 32'h0);
        chk("t1_valid0", {31'b0, InstrValidF}, 32'h0);
        tick(); #1;
        chk("t1_instr0", InstrF, 32'h1);
        chk("t1_pcf0",   PCF, 32'h0);
        chk("t1_pcp4_0", PCPlus4F, 32'h4);
        chk("t1_valid1", {31'b0, InstrValidF}, 32'h1);
        chk("t1_addr1",  imem_addr, 32'h4);
        tick();
        ws = 4'd2;
        #1;
        chk("t1_instr1", InstrF, 32'h5);
        chk("t1_pcp4_1", PCPlus4F, 32'h8);
        chk("t1_addr2",  imem_addr, 32'h8);

        // T2: two wait states
        tick(); #1;
        chk("t2_bub1_v", {31'b0, InstrValidF}, 32'h0);
        chk("t2_bub1_i", InstrF, 32'h13);
        chk("t2_hold1",  imem_addr, 32'h8);
        tick(); #1;
        chk("t2_bub2_i", InstrF, 32'h13);
        chk("t2_hold2",  imem_addr, 32'h8);
        tick(); #1;
        chk("t2_instr",  InstrF, 32'h9);
        chk("t2_pcf",    PCF, 32'h8);
        chk("t2_addr",   imem_addr, 32'hC);
        tick(); #1;
        chk("t2_bub3_v", {31'b0, InstrValidF}, 32'h0);
        tick(); tick();
        ws = 4'd0;
        #1;
        chk("t2_instr2", InstrF, 32'hD);
        chk("t2_pcf2",   PCF, 32'hC);
        chk("t2_addr2",  imem_addr, 32'h10);
        tick();
        ws = 4'd2;
        #1;
        chk("t2_instr3", InstrF, 32'h11);

        // T3: stall while the pending read is acked -> skid buffer
        tick(); tick();
        StallF = 1'b1;
        #1;
        chk("t3_req_pend", {31'b0, imem_req}, 32'h1);
        chk("t3_ack",      {31'b0, imem_ack}, 32'h1);
        tick(); #1;
        chk("t3_noreq1", {31'b0, imem_req}, 32'h0);
        chk("t3_frz_pcf", PCF, 32'h10);
        chk("t3_frz_v",  {31'b0, InstrValidF}, 32'h0);
        tick(); #1;
        chk("t3_noreq2", {31'b0, imem_req}, 32'h0);
        tick();
        StallF = 1'b0; ws = 4'd0;
        #1;
        chk("t3_noreq3", {31'b0, imem_req}, 32'h0);
        tick(); #1;
        chk("t3_skid_i", InstrF, 32'h15);
        chk("t3_skid_pc", PCF, 32'h14);
        chk("t3_skid_v", {31'b0, InstrValidF}, 32'h1);
        chk("t3_next",   imem_addr, 32'h18);
        tick();
        ack_mode = 1'b1; man_ack = 1'b0;
        #1;
        chk("t3_instr2", InstrF, 32'h19);

        // T4: redirect while a read is outstanding
        tick();
        Redirect = 1'b1; RedirectTarget = 32'h0000_0203;
        #1;
        chk("t4_pend",   {31'b0, imem_req}, 32'h1);
        tick();
        Redirect = 1'b0;
        #1;
        chk("t4_kreq",   {31'b0, imem_req}, 32'h1);
        chk("t4_kaddr",  imem_addr, 32'h1C);
        chk("t4_kval",   {31'b0, InstrValidF}, 32'h0);
        tick();
        man_ack = 1'b1;
        #1;
        chk("t4_kaddr2", imem_addr, 32'h1C);
        tick();
        ack_mode = 1'b0; man_ack = 1'b0;
        #1;
        chk("t4_addr",   imem_addr, 32'h200);
        chk("t4_drop_i", InstrF, 32'h13);
        chk("t4_drop_v", {31'b0, InstrValidF}, 32'h0);
        tick(); #1;
        chk("t4_instr",  InstrF, 32'h201);
        chk("t4_pcf",    PCF, 32'h200);

        // T5: redirect and stall together
        StallF = 1'b1; Redirect = 1'b1; RedirectTarget = 32'h0000_0400;
        tick();
        Redirect = 1'b0;
        #1;
        chk("t5_valid", {31'b0, InstrValidF}, 32'h0);
        chk("t5_instr", InstrF, 32'h13);
        chk("t5_noreq", {31'b0, imem_req}, 32'h0);
        chk("t5_addr",  imem_addr, 32'h400);
        tick();
        StallF = 1'b0;
        #1;
        chk("t5_req",   {31'b0, imem_req}, 32'h1);
        tick(); #1;
        chk("t5_tinstr", InstrF, 32'h401);
        chk("t5_tpcf",   PCF, 32'h400);

        // T6: reset PC near the top of the address space, then async reset
        chk("t6_rst_pcf",  pcf6, 32'hFFFF_FFF8);
        chk("t6_rst_pcp4", pcp46, 32'hFFFF_FFFC);
        rst6 = 1'b0;
        tick(); #1;
        chk("t6_addr0", addr6, 32'hFFFF_FFF8);
        chk("t6_req0",  {31'b0, req6}, 32'h1);
        tick(); #1;
        chk("t6_pcf0",  pcf6, 32'hFFFF_FFF8);
        chk("t6_pcp4_0", pcp46, 32'hFFFF_FFFC);
        chk("t6_addr1", addr6, 32'hFFFF_FFFC);
        tick();
        mode6 = 1'b1;
        #1;
        chk("t6_pcf1",  pcf6, 32'hFFFF_FFFC);
        chk("t6_wrap",  pcp46, 32'h0);
        chk("t6_addr2", addr6, 32'h0);
        tick(); #1;
        chk("t6_wait_req", {31'b0, req6}, 32'h1);
        #2 rst6 = 1'b1;
        #1;
        chk("t6_ar_req",   {31'b0, req6}, 32'h0);
        chk("t6_ar_pcf",   pcf6, 32'hFFFF_FFF8);
        chk("t6_ar_valid", {31'b0, valid6}, 32'h0);
        chk("t6_ar_instr", instr6, 32'h13);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
